id_ex_stage: RTL

//  ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection.

---
 rtl/id_ex_stage_pkg.sv | 25 ++
 rtl/id_ex_stage_hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle bit
// positions, the control bundle layout and the all-zero bubble.
package id_ex_stage_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int EX_REGDEST  = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    typedef struct packed {
        logic       valid;
        logic [1:0] wb;
        logic [1:0] m;
        logic [3:0] ex;
        logic       jump;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a valid load in EX whose rt feeds either source
// of the valid ID instruction stalls PC and IF/ID unless a flush is pending.
module hazard_detect (
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       flush,
    output logic       hz,
    output logic       pc_write,
    output logic       ifid_write
);

    always_comb begin
        hz = id_valid & ex_valid & ex_memread & (ex_rt != 5'd0)
           & ((ex_rt == id_rs) | (ex_rt == id_rt));
        // Reset keeps fetch running so the front end never sees a stale hold.
        pc_write   = ~hz | flush | ~rst_n;
        ifid_write = pc_write;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and
// saturating stall/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [1:0]        id_wb,
    input  logic [1:0]        id_m,
    input  logic [3:0]        id_ex,
    input  logic              id_jump,
    input  logic              id_branch,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              flush,
    output logic              ex_valid,
    output logic [1:0]        ex_wb,
    output logic [1:0]        ex_m,
    output logic [3:0]        ex_ex,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_t             ctrl_q;
    ctrl_t             ctrl_in;
    logic [DATA_W-1:0] pc4_q, rd1_q, rd2_q, imm_q;
    logic [4:0]        rs_q, rt_q, rd_q;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              hz;

    hazard_detect u_hazard (
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (ctrl_q.valid),
        .ex_memread (ctrl_q.m[M_MEMREAD]),
        .ex_rt      (rt_q),
        .flush      (flush),
        .hz         (hz),
        .pc_write   (pc_write),
        .ifid_write (ifid_write)
    );

    // An empty ID slot must not carry stray control bits into EX.
    always_comb begin
        ctrl_in = CTRL_BUBBLE;
        if (id_valid) begin
            ctrl_in.valid  = 1'b1;
            ctrl_in.wb     = id_wb;
            ctrl_in.m      = id_m;
            ctrl_in.ex     = id_ex;
            ctrl_in.jump   = id_jump;
            ctrl_in.branch = id_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_BUBBLE;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else if (flush || hz) begin
            ctrl_q <= CTRL_BUBBLE;
            pc4_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            // Flush wins: a stall coinciding with a flush is not counted.
            if (flush) begin
                if (!(&flush_q)) flush_q <= flush_q + 1'b1;
            end else begin
                if (!(&stall_q)) stall_q <= stall_q + 1'b1;
            end
        end else begin
            ctrl_q <= ctrl_in;
            pc4_q  <= id_pc4;
            rd1_q  <= id_rd1;
            rd2_q  <= id_rd2;
            imm_q  <= id_imm;
            rs_q   <= id_rs;
            rt_q   <= id_rt;
            rd_q   <= id_rd;
        end
    end

    assign ex_valid  = ctrl_q.valid;
    assign ex_wb     = ctrl_q.wb;
    assign ex_m      = ctrl_q.m;
    assign ex_ex     = ctrl_q.ex;
    assign ex_jump   = ctrl_q.jump;
    assign ex_branch = ctrl_q.branch;
    assign ex_pc4    = pc4_q;
    assign ex_rd1    = rd1_q;
    assign ex_rd2    = rd2_q;
    assign ex_imm    = imm_q;
    assign ex_rs     = rs_q;
    assign ex_rt     = rt_q;
    assign ex_rd     = rd_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
